// File: rtl/usb_phy_pkg.sv
// rtl/usb_phy_pkg.sv - shared constants and status encoding for the USB3 PHY RX elastic buffer
package usb_phy_pkg;

  localparam logic [7:0] SKP_K28_1 = 8'h3C;

  typedef enum logic [2:0] {
    ST_OK      = 3'b000,
    ST_SKP_ADD = 3'b001,
    ST_SKP_RM  = 3'b010,
    ST_OVF     = 3'b101,
    ST_UNF     = 3'b110
  } rx_status_t;

endpackage

// File: rtl/usb_phy_elastic_buf_if.sv
// rtl/usb_phy_elastic_buf_if.sv - decoder-side write and PIPE-side read signals of the elastic buffer
interface usb_phy_elastic_buf_if
  import usb_phy_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx_winc;
  logic [SYM_W-1:0] wr_data;
  logic             wr_datak;
  logic             rx_rinc;
  logic             rx_polarity;
  logic [SYM_W-1:0] rx_data;
  logic             rx_datak;
  logic             rx_valid;
  rx_status_t       rx_status;
  logic [CNT_W-1:0] fill_level;

  modport master (
    output rx_winc, wr_data, wr_datak, rx_rinc, rx_polarity,
    input  rx_data, rx_datak, rx_valid, rx_status, fill_level
  );

  modport slave (
    input  rx_winc, wr_data, wr_datak, rx_rinc, rx_polarity,
    output rx_data, rx_datak, rx_valid, rx_status, fill_level
  );

endinterface

// File: rtl/usb_phy_ebuf_mem.sv
// rtl/usb_phy_ebuf_mem.sv - symbol storage: synchronous write, asynchronous read of {K, data}
module usb_phy_ebuf_mem #(
  parameter int SYM_W  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SYM_W:0]    wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SYM_W:0]    rdata
);

  // Contents need no reset: the pointers alone define what is valid.
  logic [SYM_W:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_phy_elastic_buf.sv
// rtl/usb_phy_elastic_buf.sv - USB3 PHY RX elastic buffer: fill tracking, SKP add/remove,
// status encoding and registered PIPE outputs.
module usb_phy_elastic_buf
  import usb_phy_pkg::*;
#(
  parameter int               SYM_W   = 8,
  parameter int               DEPTH   = 16,
  parameter int               HI_WM   = DEPTH * 3 / 4,
  parameter int               LO_WM   = DEPTH / 4,
  parameter logic [SYM_W-1:0] SKP_SYM = SYM_W'(SKP_K28_1)
) (
  input  logic                  phy_clk,
  input  logic                  phy_rst,
  input  logic                  phy_clr,
  usb_phy_elastic_buf_if.slave  bus
);

  localparam int               ADDR_W = $clog2(DEPTH);
  localparam int               CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HI_C   = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_C   = CNT_W'(LO_WM);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, fill;
  logic [SYM_W-1:0] rx_data_q, rx_data_d;
  logic             rx_datak_q, rx_datak_d;
  logic             rx_valid_q, rx_valid_d;
  rx_status_t       rx_status_q, rx_status_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic             pend_rm_q, pend_rm_d;
  logic             last_ins_q, last_ins_d;

  logic [SYM_W:0]   head;
  logic             full, empty, wr_skp, head_skp;
  logic             drop_rm, drop_ovf, do_write, do_insert;

  assign fill     = wptr_q - rptr_q;
  assign full     = (fill == FULL_C);
  assign empty    = (fill == '0);
  assign wr_skp   = bus.wr_datak && (bus.wr_data == SKP_SYM);
  assign head_skp = head[SYM_W] && (head[SYM_W-1:0] == SKP_SYM);

  // A SKP over the high watermark is dropped before the full check; a full
  // buffer still accepts a write when the same-cycle read frees a slot.
  assign drop_rm   = bus.rx_winc && wr_skp && (fill > HI_C);
  assign drop_ovf  = bus.rx_winc && !drop_rm && full && !bus.rx_rinc;
  assign do_write  = bus.rx_winc && !drop_rm && !drop_ovf && !phy_clr;
  assign do_insert = head_skp && (fill < LO_C) && !last_ins_q;

  usb_phy_ebuf_mem #(
    .SYM_W  (SYM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (phy_clk),
    .we    (do_write),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata ({bus.wr_datak, bus.wr_data}),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (head)
  );

  always_comb begin
    wptr_d      = do_write ? (wptr_q + ONE_C) : wptr_q;
    rptr_d      = rptr_q;
    rx_data_d   = rx_data_q;
    rx_datak_d  = rx_datak_q;
    rx_valid_d  = 1'b0;
    rx_status_d = ST_OK;
    pend_ovf_d  = pend_ovf_q || drop_ovf;
    pend_rm_d   = pend_rm_q || drop_rm;
    last_ins_d  = last_ins_q;

    if (bus.rx_rinc) begin
      if (empty) begin
        rx_status_d = ST_UNF;
      end else begin
        rx_valid_d = 1'b1;
        rx_datak_d = head[SYM_W];
        rx_data_d  = bus.rx_polarity ? ~head[SYM_W-1:0] : head[SYM_W-1:0];
        last_ins_d = do_insert;
        if (!do_insert) begin
          rptr_d = rptr_q + ONE_C;
        end
        // Only the reported flag clears; a new event of the same kind re-arms it.
        if (pend_ovf_q) begin
          rx_status_d = ST_OVF;
          pend_ovf_d  = drop_ovf;
        end else if (pend_rm_q) begin
          rx_status_d = ST_SKP_RM;
          pend_rm_d   = drop_rm;
        end else if (do_insert) begin
          rx_status_d = ST_SKP_ADD;
        end
      end
    end

    if (phy_clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      rx_data_d   = '0;
      rx_datak_d  = 1'b0;
      rx_valid_d  = 1'b0;
      rx_status_d = ST_OK;
      pend_ovf_d  = 1'b0;
      pend_rm_d   = 1'b0;
      last_ins_d  = 1'b0;
    end
  end

  always_ff @(posedge phy_clk or posedge phy_rst) begin
    if (phy_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rx_data_q   <= '0;
      rx_datak_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_status_q <= ST_OK;
      pend_ovf_q  <= 1'b0;
      pend_rm_q   <= 1'b0;
      last_ins_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rx_data_q   <= rx_data_d;
      rx_datak_q  <= rx_datak_d;
      rx_valid_q  <= rx_valid_d;
      rx_status_q <= rx_status_d;
      pend_ovf_q  <= pend_ovf_d;
      pend_rm_q   <= pend_rm_d;
      last_ins_q  <= last_ins_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_datak   = rx_datak_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_status  = rx_status_q;
  assign bus.fill_level = fill;

endmodule
